// File: rtl/prefetch_pkg.sv
// ============================================================================
// prefetch_pkg : shared FSM encoding, NOP constant and queue entry layout
// Revision     : 1.0
// ============================================================================
`default_nettype none

package prefetch_pkg;

  typedef enum logic [1:0] {
    ST_REQUEST = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// prefetch_fifo : PC/instruction queue with flush; head is read combinationally
// Revision      : 1.0
// ============================================================================
`default_nettype none

module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  entry_t                   i_entry,
  input  logic                     i_pop,
  output entry_t                   o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W:0]     r_count;

  // A push onto a full queue is only ever paired with a pop of the same slot,
  // so writing at r_wr == r_rd never overwrites a live entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{pc: RESET_PC, instr: c_nop};
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instruction_prefetch_queue.sv
// ============================================================================
// instruction_prefetch_queue : sequential fetch, one outstanding read, redirect
// flush/discard. Optional macro PREFETCH_MISALIGN_CHECK_EN adds misaligned/HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        redirect_enable,
  input  logic [31:0] redirect_PC,
  output logic        mem_request,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] instruction,
  output logic [31:0] instruction_PC,
  output logic        instruction_valid,
  input  logic        decode_ready
`ifdef PREFETCH_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_depth = DEPTH[PTR_W:0];

  state_t         r_state, w_state_n;
  logic           r_req,   w_req_n;
  logic [31:0]    r_addr,  w_addr_n;
  logic [31:0]    r_pc,    w_pc_n;

  logic           w_accept;
  logic           w_pop;
  logic           w_flush;
  logic           w_room;
  logic [31:0]    w_target;
  logic [31:0]    w_pc_inc;
  logic [PTR_W:0] w_count;
  logic [PTR_W:0] w_count_next;
  entry_t         w_head;

`ifdef PREFETCH_MISALIGN_CHECK_EN
  logic w_misaligned;
  logic r_mis;
  assign w_target     = redirect_PC;
  assign w_misaligned = |redirect_PC[1:0];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_mis <= 1'b0;
    else       r_mis <= redirect_enable && w_misaligned;
  end
  assign misaligned = r_mis;
`else
  logic w_unused_low;
  assign w_target     = {redirect_PC[31:2], 2'b00};
  assign w_unused_low = ^redirect_PC[1:0];
`endif

  assign w_accept     = (r_state == ST_REQUEST) && r_req && mem_ready && !redirect_enable;
  assign w_pop        = instruction_valid && decode_ready && !redirect_enable;
  assign w_flush      = redirect_enable;
  assign w_count_next = w_count + {{PTR_W{1'b0}}, w_accept} - {{PTR_W{1'b0}}, w_pop};
  assign w_room       = (w_count_next < c_depth);
  assign w_pc_inc     = r_pc + 32'd4;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_REQUEST;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_addr  <= w_addr_n;
      r_pc    <= w_pc_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_addr_n  = r_addr;
    w_pc_n    = r_pc;
    if (redirect_enable) begin
      w_pc_n = w_target;
`ifdef PREFETCH_MISALIGN_CHECK_EN
      if (w_misaligned) begin
        w_state_n = ST_HALT;
        w_req_n   = 1'b0;
      end else
`endif
      // An unfinished read must complete on the bus before the new one starts.
      if (r_req && !mem_ready) begin
        w_state_n = ST_DISCARD;
      end else begin
        w_state_n = ST_REQUEST;
        w_req_n   = 1'b1;
        w_addr_n  = w_target;
      end
    end else begin
      case (r_state)
        ST_REQUEST: begin
          if (!r_req || mem_ready) begin
            if (w_accept) w_pc_n = w_pc_inc;
            if (w_room) begin
              w_req_n  = 1'b1;
              w_addr_n = w_accept ? w_pc_inc : r_pc;
            end else begin
              w_state_n = ST_HOLD;
              w_req_n   = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (w_room) begin
            w_state_n = ST_REQUEST;
            w_req_n   = 1'b1;
            w_addr_n  = r_pc;
          end
        end
        ST_DISCARD: begin
          if (mem_ready) begin
            w_state_n = ST_REQUEST;
            w_req_n   = 1'b1;
            w_addr_n  = r_pc;
          end
        end
        ST_HALT: begin
          w_req_n = 1'b0;
        end
        default: begin
          w_state_n = ST_REQUEST;
        end
      endcase
    end
  end

  prefetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (reset),
    .i_flush (w_flush),
    .i_push  (w_accept),
    .i_entry ('{pc: r_pc, instr: mem_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_request       = r_req;
  assign mem_address       = r_addr;
  assign instruction_valid = (w_count != '0);
  assign instruction       = w_head.instr;
  assign instruction_PC    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed vector table, hand sequences
// and random traffic checked against a queue-based reference model.
`default_nettype none

module tb_instruction_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        reset;
  logic        redirect_enable;
  logic [31:0] redirect_PC;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] instruction;
  logic [31:0] instruction_PC;
  logic        instruction_valid;
  logic        decode_ready;
`ifdef PREFETCH_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  always #5 CLK = ~CLK;

  instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK               (CLK),
    .reset             (reset),
    .redirect_enable   (redirect_enable),
    .redirect_PC       (redirect_PC),
    .mem_request       (mem_request),
    .mem_address       (mem_address),
    .mem_ready         (mem_ready),
    .mem_data          (mem_data),
    .instruction       (instruction),
    .instruction_PC    (instruction_PC),
    .instruction_valid (instruction_valid),
    .decode_ready      (decode_ready)
`ifdef PREFETCH_MISALIGN_CHECK_EN
    ,
    .misaligned        (misaligned)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched words plus the single outstanding read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_req, m_drop, m_halt, m_mis;
  logic [31:0] m_addr, m_pc;

  task automatic model_reset();
    mq.delete();
    m_req  = 0;
    m_drop = 0;
    m_halt = 0;
    m_mis  = 0;
    m_addr = RESET_PC;
    m_pc   = RESET_PC;
  endtask

  task automatic model_edge();
    bit          pop;
    logic [31:0] tgt;
    pop   = (mq.size() > 0) && decode_ready;
    m_mis = 0;
    if (redirect_enable) begin
      mq.delete();
`ifdef PREFETCH_MISALIGN_CHECK_EN
      tgt = redirect_PC;
      if (tgt[1:0] != 2'b00) begin
        m_mis  = 1;
        m_halt = 1;
        m_req  = 0;
        m_drop = 0;
        return;
      end
`else
      tgt = redirect_PC & ~32'h3;
`endif
      m_pc   = tgt;
      m_halt = 0;
      if (m_req && !mem_ready) m_drop = 1;
      else begin
        m_drop = 0;
        m_req  = 1;
        m_addr = tgt;
      end
    end else if (m_halt) begin
      m_req = 0;
    end else if (m_drop) begin
      if (mem_ready) begin
        m_drop = 0;
        m_req  = 1;
        m_addr = m_pc;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_req && mem_ready) begin
        mq.push_back('{pc: m_addr, ins: mem_data});
        m_pc  = m_pc + 32'd4;
        m_req = 0;
      end
      if (!m_req) begin
        if (mq.size() < DEPTH) begin
          m_req  = 1;
          m_addr = m_pc;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model.req", {31'd0, mem_request}, {31'd0, m_req});
    if (m_req) chk("model.addr", mem_address, m_addr);
    chk("model.valid", {31'd0, instruction_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("model.pc", instruction_PC, mq[0].pc);
      chk("model.ins", instruction, mq[0].ins);
    end
`ifdef PREFETCH_MISALIGN_CHECK_EN
    chk("model.misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`endif
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc, input bit mr,
                      input bit dr, input logic [31:0] md);
    redirect_enable = rd;
    redirect_PC     = rpc;
    mem_ready       = mr;
    decode_ready    = dr;
    mem_data        = md;
    model_edge();
    @(posedge CLK);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".req"},   {31'd0, mem_request}, 32'd0);
    chk({tag, ".addr"},  mem_address, RESET_PC);
    chk({tag, ".valid"}, {31'd0, instruction_valid}, 32'd0);
    chk({tag, ".ins"},   instruction, NOP);
    chk({tag, ".pc"},    instruction_PC, RESET_PC);
`ifdef PREFETCH_MISALIGN_CHECK_EN
    chk({tag, ".mis"},   {31'd0, misaligned}, 32'd0);
`endif
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] rpc;
    bit          mr;
    bit          dr;
    logic [31:0] md;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vt[11];

  initial begin
    // Stream 0,4,8 then stall decode until the queue fills, then drain one.
    vt[0]  = '{0, 0, 1, 1, 32'hD000_0000, 1, 32'h00, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 1, 32'hD000_0000, 1, 32'h04, 1, 32'h00, 32'hD000_0000};
    vt[2]  = '{0, 0, 1, 1, 32'hD000_0004, 1, 32'h08, 1, 32'h04, 32'hD000_0004};
    vt[3]  = '{0, 0, 1, 1, 32'hD000_0008, 1, 32'h0C, 1, 32'h08, 32'hD000_0008};
    vt[4]  = '{0, 0, 1, 0, 32'hD000_000C, 1, 32'h10, 1, 32'h08, 32'hD000_0008};
    vt[5]  = '{0, 0, 1, 0, 32'hD000_0010, 1, 32'h14, 1, 32'h08, 32'hD000_0008};
    vt[6]  = '{0, 0, 1, 0, 32'hD000_0014, 0, 32'h00, 1, 32'h08, 32'hD000_0008};
    vt[7]  = '{0, 0, 0, 0, 32'h0,         0, 32'h00, 1, 32'h08, 32'hD000_0008};
    vt[8]  = '{0, 0, 0, 1, 32'h0,         1, 32'h18, 1, 32'h0C, 32'hD000_000C};
    vt[9]  = '{0, 0, 1, 1, 32'hD000_0018, 1, 32'h1C, 1, 32'h10, 32'hD000_0010};
    vt[10] = '{0, 0, 1, 1, 32'hD000_001C, 1, 32'h20, 1, 32'h14, 32'hD000_0014};

    reset = 1; redirect_enable = 0; redirect_PC = 0;
    mem_ready = 0; mem_data = 0; decode_ready = 0;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    check_reset_values("reset");
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      step(vt[i].rd, vt[i].rpc, vt[i].mr, vt[i].dr, vt[i].md);
      chk($sformatf("vec%0d.req", i), {31'd0, mem_request}, {31'd0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("vec%0d.addr", i), mem_address, vt[i].e_addr);
      chk($sformatf("vec%0d.valid", i), {31'd0, instruction_valid}, {31'd0, vt[i].e_valid});
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d.pc", i), instruction_PC, vt[i].e_pc);
        chk($sformatf("vec%0d.ins", i), instruction, vt[i].e_ins);
      end
    end

    // Redirect while read of 0x20 waits three cycles: address held, data dropped.
    step(1, 32'h100, 0, 0, 0);
    chk("disc.valid", {31'd0, instruction_valid}, 32'd0);
    chk("disc.addr0", mem_address, 32'h20);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("disc.addr2", mem_address, 32'h20);
    step(0, 0, 1, 0, 32'hBAD0_0020);
    chk("disc.valid_after", {31'd0, instruction_valid}, 32'd0);
    chk("disc.newaddr", mem_address, 32'h100);
    step(0, 0, 1, 0, 32'hC0DE_0100);
    chk("disc.pc", instruction_PC, 32'h100);
    chk("disc.ins", instruction, 32'hC0DE_0100);

    // Redirect coinciding with mem_ready: returned word dropped.
    step(1, 32'h240, 1, 0, 32'hBAD0_0104);
    chk("same.valid", {31'd0, instruction_valid}, 32'd0);
    chk("same.addr", mem_address, 32'h240);
    step(0, 0, 1, 1, 32'hC0DE_0240);
    chk("same.pc", instruction_PC, 32'h240);
    chk("same.ins", instruction, 32'hC0DE_0240);

    // Misaligned redirect target.
    step(1, 32'h302, 0, 0, 0);
`ifdef PREFETCH_MISALIGN_CHECK_EN
    chk("mis.pulse", {31'd0, misaligned}, 32'd1);
    chk("mis.req", {31'd0, mem_request}, 32'd0);
    step(0, 0, 1, 0, 0);
    chk("mis.pulse_end", {31'd0, misaligned}, 32'd0);
    chk("mis.halt_req", {31'd0, mem_request}, 32'd0);
    step(1, 32'h200, 0, 0, 0);
    chk("mis.resume", mem_address, 32'h200);
`else
    chk("mis.held", mem_address, 32'h244);
    step(0, 0, 1, 0, 32'hBAD0_0244);
    chk("mis.forced", mem_address, 32'h300);
`endif

    // Asynchronous reset in the middle of a cycle.
    step(0, 0, 1, 0, 32'h1234_5678);
    #3 reset = 1;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(posedge CLK); #1;
    reset = 0;

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'h0000_FFFF;
      if (($urandom % 8) != 0) rpc = rpc & ~32'h3;
      step(($urandom % 100) < 4, rpc, ($urandom % 100) < 60,
           ($urandom % 100) < 65, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Front-end stage that sits directly upstream of the fetch/decode path. It issues sequential instruction reads to instruction memory through a request/ready handshake, buffers returned words with their PCs in a small FIFO, and presents them to decode through a valid/ready interface. It also handles jump/branch redirects by flushing the queue and discarding any in-flight read.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- redirect_enable  input  1  jump/branch taken; single-cycle pulse.
- redirect_PC  input  32  new fetch target, valid with redirect_enable.
- mem_request  output  1  read request to instruction memory.
- mem_address  output  32  read address; held stable while mem_request is high.
- mem_ready  input  1  read complete; mem_data is valid in the same cycle.
- mem_data  input  32  returned instruction word.
- instruction  output  32  head-of-queue instruction.
- instruction_PC  output  32  PC of the head instruction.
- instruction_valid  output  1  head entry present.
- decode_ready  input  1  decode accepts the head this cycle.
- misaligned  output  1  misaligned redirect flag; present only with PREFETCH_MISALIGN_CHECK_EN.

## Operation
- FSM states:
  - REQUEST: read outstanding.
  - HOLD: queue full, no request.
  - DISCARD: in-flight read is being dropped after a redirect.
  - HALT: only with the macro.
- One outstanding read at most. A request is issued only when the queue count is below DEPTH, so returned data always has a slot.
- Accept: in REQUEST with mem_ready=1 and no redirect:
  - push {fetch_PC, mem_data};
  - fetch_PC += 4 (mod 2^32 wrap);
  - next request issued the following cycle if count < DEPTH, else go to HOLD.
- Pop: instruction_valid & decode_ready. Push and pop in the same cycle leave count unchanged, which is legal even when the queue is full.
- HOLD -> REQUEST on the first cycle that count < DEPTH.
- Redirect (priority over push and pop):
  - queue count set to 0 and fetch_PC set to redirect_PC.
  - If a read is outstanding and mem_ready=0: go to DISCARD. mem_request and the old mem_address stay held until mem_ready; that data is dropped; then go to REQUEST with the new PC.
  - If mem_ready=1 in the redirect cycle: the data is dropped and the FSM goes straight to REQUEST.
  - A second redirect while in DISCARD overwrites fetch_PC and stays in DISCARD.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - mem_request=0, mem_address=RESET_PC;
  - instruction_valid=0, instruction=32'h0000_0013 (NOP), instruction_PC=RESET_PC;
  - misaligned=0;
  - FSM=REQUEST with request deasserted for the reset cycle.
- First mem_request=1 in the first cycle after reset deasserts.
- Latency: data accepted at edge k gives instruction_valid=1 after edge k.
- Throughput: one instruction per cycle when mem_ready is tied high and decode_ready=1.
- Redirect at edge r:
  - instruction_valid=0 after r;
  - mem_address=redirect_PC after r, or after the DISCARD completes.
- Reset mid-operation clears queue, FSM and outputs immediately (asynchronous). An outstanding memory read is abandoned.
- Outputs are registered except instruction/instruction_PC, which are read combinationally from the head entry.

## Configuration
- PREFETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_PC[1:0] != 0 flushes the queue, pulses misaligned for exactly one cycle, and enters HALT with no requests.
  - HALT exits only on an aligned redirect.
- Undefined:
  - redirect_PC[1:0] is forced to 2'b00;
  - no misaligned port;
  - no HALT state.

## Structure
- Shared package prefetch_pkg holds:
  - FSM state encoding (REQUEST, HOLD, DISCARD, HALT);
  - NOP constant 32'h0000_0013;
  - the queue entry layout {PC[31:0], instruction[31:0]}.
- One sub-module, prefetch_fifo: storage, pointers, count, flush input. The FSM and PC logic stay in the top module.

## Test plan
- Reset release, mem_ready tied 1, decode_ready=1 -> mem_address 0x0, 0x4, 0x8 on consecutive cycles; instruction_PC follows one cycle later with matching mem_data.
- decode_ready=0, DEPTH=4 -> after 4 accepts mem_request=0 (HOLD). One pop -> request for 0x10 reissued the next cycle.
- Redirect to 0x100 while a read of 0x8 is outstanding with mem_ready delayed 3 cycles -> mem_address stays 0x8 until ready; the 0x8 data is never valid; the next request is 0x100.
- Redirect and mem_ready in the same cycle -> returned word dropped, instruction_valid=0 next cycle, next mem_address=redirect_PC.
- Queue full with simultaneous push and pop -> count stays 4, order preserved, no lost or duplicated PC.
- With the macro, redirect to 0x102 -> misaligned high for one cycle, no mem_request. A later redirect to 0x200 resumes fetch at 0x200.
